trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer_pkg.sv | 26 ++
 rtl/trace_buffer_fifo.sv | 72 +++++++
 rtl/trace_buffer.sv | 144 ++++++++++++++
 tb/tb_trace_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/trace_buffer_pkg.sv
// Shared constants and types for the CPU trace buffer.
package trace_buffer_pkg;

  // One trace record is {PC, Inst, R}, 32 bits each.
  localparam int unsigned REC_W     = 96;
  localparam int unsigned REC_BYTES = 12;
  localparam int unsigned IDX_W     = 4;

  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_DROPW = 8;

  typedef logic [REC_W-1:0] rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Record layout: PC occupies the most significant word so it is sent first.
  function automatic rec_t pack_rec(input logic [31:0] pc,
                                    input logic [31:0] inst,
                                    input logic [31:0] r);
    return {pc, inst, r};
  endfunction

endpackage

// File: rtl/trace_buffer_fifo.sv
// Register-based record FIFO with power-of-two depth and an occupancy count.
// The owner guarantees push only when not full (or with a simultaneous pop)
// and pop only when not empty.
module trace_fifo
  import trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  rec_t                   wdata,
  output rec_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] count_q, count_d;

  assign rdata = mem_q[rptr_q];
  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;

  // Next-state for storage, pointers (wrap naturally at DEPTH) and count.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/trace_buffer.sv
// CPU trace buffer: captures {PC, Inst, R} per enabled cycle into a FIFO and
// streams each record out MSB-first as 12 bytes over a valid/ready port.
// Records arriving while the FIFO is full are dropped and counted.
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned DROPW = DEF_DROPW
) (
  input  logic                   Clk,
  input  logic                   Clr,
  input  logic                   En,
  input  logic [31:0]            PC,
  input  logic [31:0]            Inst,
  input  logic [31:0]            R,
  output logic [7:0]             Dout,
  output logic                   Dvalid,
  input  logic                   Dready,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Ovf,
  output logic [DROPW-1:0]       Drops
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  rec_t fifo_head;
  logic drop;

  ser_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  rec_t             sh_q, sh_d;
  logic             dvalid_q, dvalid_d;
  logic             ovf_q, ovf_d;
  logic [DROPW-1:0] drops_q, drops_d;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pack_rec(PC, Inst, R)),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (Level)
  );

  // The shift register is cleared whenever the serializer goes idle, so its
  // top byte doubles as Dout and reads zero while Dvalid is low.
  assign Dout   = sh_q[REC_W-1 -: 8];
  assign Dvalid = dvalid_q;
  assign Ovf    = ovf_q;
  assign Drops  = drops_q;

  // Serializer: load a record from the FIFO, shift out one byte per transfer,
  // and chain straight into the next record without a bubble.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_head;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Dready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              sh_d     = fifo_head;
            end else begin
              sh_d    = '0;
              state_d = ST_IDLE;
            end
          end else begin
            sh_d  = sh_q << 8;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        sh_d    = '0;
      end
    endcase
    dvalid_d = (state_d == ST_SEND);
  end

  // Capture and overflow: a push into a full FIFO is accepted only when the
  // serializer pops on the same edge; otherwise it is dropped and counted.
  always_comb begin
    fifo_push = En && (!fifo_full || fifo_pop);
    drop      = En && fifo_full && !fifo_pop;
    ovf_d     = ovf_q;
    drops_d   = drops_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_q != '1) begin
        drops_d = drops_q + 1'b1;
      end
    end
  end

  // Serializer FSM and its registered outputs; reset aborts any record.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      sh_q     <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Sticky overflow flag and saturating drop counter, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: a record-level reference model predicts
// FIFO occupancy, drop accounting and the expected byte stream; a separate
// monitor compares the DUT against it on every falling edge.
module tb_trace_buffer;
  import trace_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int DROPW = 8;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        En = 1'b0;
  logic        Dready = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] Inst = '0;
  logic [31:0] R = '0;
  logic [7:0]  Dout;
  logic        Dvalid;
  logic [3:0]  Level;
  logic        Ovf;
  logic [DROPW-1:0] Drops;

  trace_buffer #(
    .DEPTH (DEPTH),
    .DROPW (DROPW)
  ) dut (
    .Clk    (Clk),
    .Clr    (Clr),
    .En     (En),
    .PC     (PC),
    .Inst   (Inst),
    .R      (R),
    .Dout   (Dout),
    .Dvalid (Dvalid),
    .Dready (Dready),
    .Level  (Level),
    .Ovf    (Ovf),
    .Drops  (Drops)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  logic [95:0] m_fifo[$];
  int          m_rem = 0;     // bytes of the current record still to send
  bit          m_ovf = 0;
  int          m_drops = 0;
  logic [7:0]  exp_q[$];      // scoreboard: expected output byte stream

  bit stim_done = 0;
  bit drain_fail = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: advances once per rising edge from the driven inputs.
  always @(posedge Clk) begin : model
    bit          xfer;
    bit          pop;
    logic [95:0] rec;
    if (Clr) begin
      m_fifo.delete();
      exp_q.delete();
      m_rem   = 0;
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      xfer = (m_rem > 0) && Dready;
      pop  = (m_fifo.size() > 0) && ((m_rem == 0) || (xfer && m_rem == 1));
      if (xfer) m_rem = m_rem - 1;
      if (pop) begin
        void'(m_fifo.pop_front());
        m_rem = 12;
      end
      if (En) begin
        if (m_fifo.size() < DEPTH) begin
          rec = {PC, Inst, R};
          m_fifo.push_back(rec);
          for (int k = 0; k < 12; k++) exp_q.push_back(rec[95 - 8*k -: 8]);
        end else begin
          m_ovf = 1;
          if (m_drops < (2**DROPW) - 1) m_drops = m_drops + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs with the model between clock edges.
  initial begin : monitor
    logic [7:0] prev_dout;
    bit         prev_hold;
    logic [7:0] b;
    prev_hold = 0;
    prev_dout = '0;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      if (stim_done) break;
      chk("dvalid", longint'(Dvalid), longint'(m_rem > 0));
      chk("level", longint'(Level), longint'(m_fifo.size()));
      chk("ovf", longint'(Ovf), longint'(m_ovf));
      chk("drops", longint'(Drops), longint'(m_drops));
      if (!Dvalid) chk("dout_idle_zero", longint'(Dout), 0);
      if (prev_hold) chk("dout_hold", longint'(Dout), longint'(prev_dout));
      if (Dvalid && Dready && !Clr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", longint'(Dout), -1);
        end else begin
          b = exp_q.pop_front();
          chk("byte", longint'(Dout), longint'(b));
        end
      end
      prev_hold = Dvalid && !Dready && !Clr;
      prev_dout = Dout;
    end
    chk("drain_timeout", longint'(drain_fail), 0);
    chk("bytes_left", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step_rec(input bit en, input bit rdy, input bit clr,
                          input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] r);
    En = en; Dready = rdy; Clr = clr; PC = pc; Inst = inst; R = r;
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input bit en, input bit rdy, input bit clr);
    step_rec(en, rdy, clr, $urandom, $urandom, $urandom);
  endtask

  // Stimulus: directed scenarios, drop-counter saturation, then random traffic.
  initial begin : stim
    repeat (3) step(0, 0, 1);
    // single known record
    step_rec(1, 1, 0, 32'h0000_0004, 32'h2008_0005, 32'h0000_0005);
    repeat (15) step(0, 1, 0);
    // back-to-back records without a gap
    repeat (3) step(1, 1, 0);
    repeat (40) step(0, 1, 0);
    // fill with sink stalled: level saturates, three drops
    repeat (12) step(1, 0, 0);
    // bytes 0..2, stall on byte 3, then resume
    repeat (3) step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    repeat (10) step(0, 1, 0);
    // full FIFO with pushes coinciding with record boundaries
    repeat (40) step(1, 1, 0);
    // partial drain, reset mid-record, restart
    repeat (54) step(0, 1, 0);
    step(0, 1, 1);
    step(1, 1, 0);
    repeat (15) step(0, 1, 0);
    // drop counter saturation
    repeat (300) step(1, 0, 0);
    repeat (20) step(0, 1, 0);
    step(0, 0, 1);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 70,
           $urandom_range(0, 199) == 0);
    end
    // drain everything
    for (int i = 0; i < 400 && (exp_q.size() > 0 || m_rem > 0); i++) step(0, 1, 0);
    if (exp_q.size() > 0 || m_rem > 0) drain_fail = 1;
    stim_done = 1;
  end

endmodule
